// File: rtl/sort_mem_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sort_mem_if : single-port data memory bus shared by the sort sequencer
// Revision: 1.0
// ---------------------------------------------------------------------------
interface sort_mem_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              write_en;
    logic              mode;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (
        output write_en, mode, address, data_in,
        input  data_out
    );

    modport slave (
        input  write_en, mode, address, data_in,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/sort_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sort_sequencer : in-place ascending bubble sort (early exit) over data memory
// Revision: 1.0
// ---------------------------------------------------------------------------
module sort_sequencer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int SIZE_ADDR = 1,
    parameter int BASE_ADDR = 2,
    parameter int CNT_W     = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             start,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    sort_mem_if.master            mem,
    output logic [CNT_W-1:0]      swap_count,
    output logic [CNT_W-1:0]      pass_count
);

    localparam logic [ADDR_W-1:0] SIZE_A = ADDR_W'(SIZE_ADDR);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   MAX_N  = (ADDR_W+1)'((2**ADDR_W) - BASE_ADDR);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [3:0] {
        IDLE = 4'd0,  RD_N = 4'd1,  LD_N = 4'd2,  CHK  = 4'd3,
        RD_A = 4'd4,  LD_A = 4'd5,  RD_B = 4'd6,  LD_B = 4'd7,
        CMP  = 4'd8,  WR_A = 4'd9,  WR_B = 4'd10, ADV  = 4'd11,
        PASS = 4'd12, ERR  = 4'd13, DONE = 4'd14
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W:0]     n;
    logic                n_bad;
    logic [ADDR_W:0]     limit;
    logic [ADDR_W-1:0]   j;
    logic [ADDR_W:0]     j_inc;
    logic                swapped;
    logic [DATA_W-1:0]   a;
    logic [DATA_W-1:0]   b;
    logic                more_in_pass;
    logic                sort_finished;

    assign j_inc         = {1'b0, j} + 1'b1;
    assign more_in_pass  = (j_inc < limit);
    assign sort_finished = !swapped || (limit == (ADDR_W+1)'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        mem.write_en = 1'b0;
        mem.mode     = 1'b0;
        mem.address  = '0;
        mem.data_in  = '0;
        busy         = (state != IDLE);
        done         = (state == DONE);
        case (state)
            IDLE: if (start) state_next = RD_N;
            RD_N: begin
                mem.address = SIZE_A;
                state_next  = LD_N;
            end
            LD_N: state_next = CHK;
            CHK: begin
                if (n_bad || (n > MAX_N))
                    state_next = ERR;
                else if (n <= (ADDR_W+1)'(1))
                    state_next = DONE;
                else
                    state_next = RD_A;
            end
            RD_A: begin
                mem.address = BASE_A + j;
                state_next  = LD_A;
            end
            LD_A: state_next = RD_B;
            RD_B: begin
                mem.address = BASE_A + j + ADDR_W'(1);
                state_next  = LD_B;
            end
            LD_B: state_next = CMP;
            CMP:  state_next = (a > b) ? WR_A : ADV;
            WR_A: begin
                mem.write_en = 1'b1;
                mem.mode     = 1'b1;
                mem.address  = BASE_A + j;
                mem.data_in  = b;
                state_next   = WR_B;
            end
            WR_B: begin
                mem.write_en = 1'b1;
                mem.mode     = 1'b1;
                mem.address  = BASE_A + j + ADDR_W'(1);
                mem.data_in  = a;
                state_next   = ADV;
            end
            ADV:  state_next = more_in_pass ? RD_A : PASS;
            PASS: state_next = sort_finished ? DONE : RD_A;
            ERR:  state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n          <= '0;
            n_bad      <= 1'b0;
            limit      <= '0;
            j          <= '0;
            swapped    <= 1'b0;
            a          <= '0;
            b          <= '0;
            err        <= 1'b0;
            swap_count <= '0;
            pass_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        swap_count <= '0;
                        pass_count <= '0;
                        err        <= 1'b0;
                    end
                end
                LD_N: begin
                    n     <= mem.data_out[ADDR_W:0];
                    // Any set bit above the count field makes n unrepresentable.
                    n_bad <= (mem.data_out[DATA_W-1:ADDR_W+1] != '0);
                end
                CHK: begin
                    limit   <= n - (ADDR_W+1)'(1);
                    j       <= '0;
                    swapped <= 1'b0;
                end
                LD_A: a <= mem.data_out;
                LD_B: b <= mem.data_out;
                CMP: begin
                    if (a > b) begin
                        swapped <= 1'b1;
                        if (swap_count != CNT_MAX)
                            swap_count <= swap_count + 1'b1;
                    end
                end
                ADV: begin
                    if (more_in_pass)
                        j <= j_inc[ADDR_W-1:0];
                end
                PASS: begin
                    if (pass_count != CNT_MAX)
                        pass_count <= pass_count + 1'b1;
                    if (!sort_finished) begin
                        limit   <= limit - (ADDR_W+1)'(1);
                        j       <= '0;
                        swapped <= 1'b0;
                    end
                end
                ERR: err <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/sort_sequencer.md
Name: sort_sequencer

Overview:
- FSM master that sorts the array in the data memory in place, ascending, using bubble sort with early exit.
- Sits between the control unit and the data memory port, and owns that port while busy.
- Reads element count n from SIZE_ADDR and elements from BASE_ADDR..BASE_ADDR+n-1.
- Writes swapped pairs back and reports completion, error and swap statistics.

Parameters:
DATA_W, 32, element/memory word width
ADDR_W, 5, memory address width (32 words)
SIZE_ADDR, 1, address holding n
BASE_ADDR, 2, address of array element 0
CNT_W, 16, swap_count / pass_count width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin sort; sampled only in IDLE
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle completion pulse (also on error)
err  output  1  n out of range; held until next accepted start or rst
mem_write_en  output  1  memory write enable
mem_mode  output  1  0 = read (with write_en=0), 1 = silent write (with write_en=1)
mem_address  output  ADDR_W  memory address
mem_data_in  output  DATA_W  write data to memory
mem_data_out  input  DATA_W  read data from memory
swap_count  output  CNT_W  swaps performed in last/current sort
pass_count  output  CNT_W  outer passes completed

Behaviour:
- Reset (async, any state): state=IDLE. busy=0, done=0, err=0, mem_write_en=0, mem_mode=0, mem_address=0, mem_data_in=0, swap_count=0, pass_count=0, internal regs=0. Memory contents are not restored: a reset between WR_A and WR_B may leave a duplicated element, which is accepted behaviour.
- Memory protocol: reads drive write_en=0, mode=0, address in cycle t; data is captured from mem_data_out at the end of cycle t+1. Writes drive write_en=1, mode=1, address and data for exactly one cycle. mem_write_en is 0 in every non-write state.
- States:
  - IDLE: start=1 -> RD_N. Clear swap_count, pass_count, err.
  - RD_N: address=SIZE_ADDR.
  - LD_N: n <= mem_data_out[ADDR_W:0] (upper bits must be 0, else error).
  - CHK:
    - n > 2^ADDR_W - BASE_ADDR -> ERR.
    - n <= 1 -> DONE.
    - else limit <= n-1, j <= 0, swapped <= 0 -> RD_A.
  - RD_A: address=BASE_ADDR+j.
  - LD_A: a <= data.
  - RD_B: address=BASE_ADDR+j+1.
  - LD_B: b <= data.
  - CMP: unsigned compare.
    - a > b: swapped <= 1, swap_count++ -> WR_A.
    - else -> ADV.
  - WR_A: write b to BASE_ADDR+j.
  - WR_B: write a to BASE_ADDR+j+1 -> ADV.
  - ADV: j+1 < limit -> j++ -> RD_A; else -> PASS.
  - PASS: pass_count++.
    - swapped=0 or limit=1 -> DONE.
    - else limit--, j <= 0, swapped <= 0 -> RD_A.
  - ERR: err <= 1 -> DONE.
  - DONE: done=1 for one cycle, busy=0 next -> IDLE.
- busy: 1 in every state except IDLE. done and busy both read 1 during the DONE cycle.
- Equal elements are never swapped (stable; no write traffic).
- start while busy: ignored, no effect. start held high after DONE: a new sort starts from IDLE.
- Counters saturate at 2^CNT_W-1, with no wrap.
- Latency per compare: 6 cycles without a swap, 8 with a swap.

Test Plan:
- Init n=10, array 2,3,2,2,6,1,4,3,2,1; pulse start -> memory[2..11]=1,1,2,2,2,2,3,3,4,6; swap_count=22; err=0; single done pulse.
- n=4, array 1,2,3,4 -> no mem_write_en asserted; swap_count=0; pass_count=1; done exactly 23 cycles after the start-sampling edge.
- n=1 -> done 4 cycles after start; no array reads; swap_count=0. n=0 -> same timing.
- n=31 -> err=1 with done; no array access; memory unchanged. n=30 with reversed values 30..1 -> sorted 1..30, swap_count=435.
- Re-pulse start mid-sort on n=10 case -> ignored; final result identical to first scenario.
- Assert rst during WR_B of a swap -> all outputs 0 immediately (async), state IDLE. A new start then sorts successfully from the current memory contents.
